// File: rtl/uart_fifo_tx_if.sv
// Handshake between the UART transmitter and the FIFO read port it drains.
interface uart_fifo_tx_if #(
    parameter int unsigned DW = 7
);
    logic          empty;
    logic [DW:0]   rd_data;
    logic          tx;
    logic          busy;
    logic          transmit_complete;

    // FIFO / environment side
    modport master (
        output empty,
        output rd_data,
        input  tx,
        input  busy,
        input  transmit_complete
    );

    // Transmitter side
    modport slave (
        input  empty,
        input  rd_data,
        output tx,
        output busy,
        output transmit_complete
    );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter fed from a FIFO read port: latches the head word, sends one frame,
// and pops the FIFO on the final cycle of the stop bit.
module uart_fifo_tx #(
    parameter int unsigned DW           = 7,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic           clk,
    input  logic           reset,
    uart_fifo_tx_if.slave  bus
);
    localparam int unsigned W      = DW + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = (DW > 0) ? $clog2(DW + 1) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DW);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [W-1:0]      shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              tc_q, tc_d;
    logic              bit_end;

    // State and output registers; outputs are precomputed from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state, datapath and registered-output precompute
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        tc_d    = 1'b0;
        bit_end = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (!bus.empty) begin
                    shreg_d = bus.rd_data;
                    par_d   = ^bus.rd_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        // Pop strobe lands on the last cycle of the stop bit
        tc_d   = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
    end

    assign bus.tx                = tx_q;
    assign bus.busy              = busy_q;
    assign bus.transmit_complete = tc_q;
endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 The block SHALL have parameter DW, default 7, giving data word MSB index (word width DW+1).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 5208, giving clk cycles per serial bit (50 MHz / 9600 baud); legal range is 2 or more.
REQ-003 The block SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 empty  input  1  upstream FIFO empty flag; 1 = no word available.
REQ-007 rd_data  input  DW+1  upstream FIFO head word; valid whenever empty=0.
REQ-008 tx  output  1  serial line; idle/mark = 1.
REQ-009 busy  output  1  1 while a frame is in progress (any state other than IDLE).
REQ-010 transmit_complete  output  1  single-cycle pop strobe to the FIFO read port; the FIFO advances its read pointer on this strobe.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: tx=1 and busy=0; when empty=0 at a clk edge, the block SHALL latch rd_data into the shift register, clear the baud and bit counters, and enter START.
REQ-013 IDLE with empty=1 SHALL hold IDLE without limit; rd_data SHALL be ignored.
REQ-014 The baud counter SHALL count 0..CLKS_PER_BIT-1 and be $clog2(CLKS_PER_BIT) bits wide; each bit period SHALL last exactly CLKS_PER_BIT clk cycles.
REQ-015 START: tx=0 for one bit period, then enter DATA.
REQ-016 DATA: tx SHALL carry the shift register LSB; at the end of each bit period the register SHALL shift right by one.
REQ-017 DATA SHALL transmit exactly DW+1 bits, LSB first, with the bit index running 0..DW.
REQ-018 After bit DW, the FSM SHALL enter PARITY if PARITY_EN=1, else STOP.
REQ-019 PARITY: tx SHALL be the XOR of the latched word (even parity) for one bit period, then enter STOP.
REQ-020 The parity value SHALL be computed from the word latched at frame start, not from live rd_data.
REQ-021 STOP: tx=1 for one bit period.
REQ-022 transmit_complete SHALL be 1 for exactly the last clk cycle of STOP, then the FSM SHALL enter IDLE.
REQ-023 transmit_complete SHALL be 1 exactly once per frame and SHALL never be 1 when empty=1 was sampled at frame start.
REQ-024 The FIFO word SHALL stay un-popped until STOP completes; the latched copy SHALL drive the frame, so mid-frame changes on rd_data or empty SHALL NOT affect tx.
REQ-025 Back-to-back frames: after transmit_complete there SHALL be one IDLE cycle with tx=1, in which the updated empty is sampled; if empty=0, START SHALL begin on the next cycle.
REQ-026 Frame length SHALL be (DW+3+PARITY_EN)*CLKS_PER_BIT cycles from START entry to IDLE re-entry.
REQ-027 The block SHALL drive tx, busy and transmit_complete from registers only.

Reset
REQ-028 While reset=1, the block SHALL force state=IDLE, tx=1, busy=0, transmit_complete=0, and clear the baud counter, bit counter and shift register.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no transmit_complete; the word stays in the FIFO and SHALL be resent in full after reset.
REQ-030 After reset deasserts, the first START SHALL occur no earlier than the second clk edge, with IDLE sampling empty on the first edge.

Verification (CLKS_PER_BIT=4, DW=7 unless stated)
REQ-031 Reset pulse mid-operation -> tx=1, busy=0 and transmit_complete=0 the same cycle; no pulse follows.
REQ-032 empty=0, rd_data=8'hA5, PARITY_EN=0 -> tx holds 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; transmit_complete=1 in cycle 40 only.
REQ-033 Two words 8'h01 then 8'hFF queued -> two 40-cycle frames separated by exactly one idle cycle; exactly two transmit_complete pulses.
REQ-034 empty held at 1 for 1000 cycles with rd_data toggling -> tx stays 1, busy=0, no transmit_complete.
REQ-035 PARITY_EN=1, word 8'h07 -> parity bit 1 after the data bits; frame of 44 cycles; word 8'h03 -> parity bit 0.
REQ-036 Reset asserted at data bit 3 of 8'h5A with empty still 0 -> frame aborts; after release, full 8'h5A frame resent and one transmit_complete seen.
